div_pnt_seq: RTL and testbench

Sequencer for the reciprocal / inverse-square-root slope-intercept table (div_pnt_slp) in the VU divide unit. It accepts one 32-bit unsigned operand per transaction and normalises it. It then forms the 6-bit table index, reads the table, and linearly interpolates to a 16-bit mantissa plus a 5-bit exponent. Operands arrive on a valid/ready handshake from VU issue, and results return the same way to the VU writeback stage.

---
 rtl/div_pnt_seq_if.sv | 24 ++
 rtl/div_pnt_seq.sv | 162 ++++++++++++++++
 tb/tb_div_pnt_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pnt_seq_if.sv
// Operand/result handshake bundle between VU issue, the divide-point sequencer and VU writeback.
interface div_pnt_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mant;
    logic [4:0]  out_exp;
    logic        out_dbz;

    // Sequencer side.
    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_dbz
    );

    // Issue/writeback side.
    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_dbz
    );
endinterface

// File: rtl/div_pnt_seq.sv
// Reciprocal / inverse-square-root sequencer: normalise, index the slope-intercept
// table, then linearly interpolate to a Q0.16 mantissa and a 5-bit exponent.
module div_pnt_seq #(
    parameter int unsigned FRAC_W = 8
) (
    input  logic          clk,
    input  logic          reset_l,
    div_pnt_seq_if.slave  bus,
    input  logic          flush,
    output logic [5:0]    tbl_index,
    input  logic [23:0]   tbl_data,
    output logic          busy
);

    localparam int unsigned PROD_W = 13 + FRAC_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_LOOK = 3'd2,
        S_INTP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_op;
    logic [31:0]         r_data;
    logic [FRAC_W-1:0]   r_frac;
    logic [4:0]          r_exp;
    logic [23:0]         r_tbl;
    logic [5:0]          r_tbl_index;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [15:0]         r_out_mant;
    logic [4:0]          r_out_exp;
    logic                r_out_dbz;
    logic                r_busy;

    logic [4:0]          w_p;
    logic [31:0]         w_norm;
    logic [5:0]          w_index;
    logic [FRAC_W-1:0]   w_frac;
    logic [4:0]          w_exp;
    logic [7:0]          w_slope;
    logic [15:0]         w_incpt;
    logic [12:0]         w_delta;
    logic [PROD_W-1:0]   w_prod;
    logic [12:0]         w_corr;
    logic [16:0]         w_sub;
    logic [15:0]         w_mant;
    logic                w_unused;

    // Leading-one position of the captured operand (0 when the operand is zero).
    always_comb begin
        w_p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_data[i]) w_p = 5'(i);
        end
    end

    assign w_norm = r_data << (5'd31 - w_p);

    // Inverse square root uses the upper half of the table, split by exponent parity.
    assign w_index = r_op ? {1'b1, ~w_p[0], w_norm[30:27]} : {1'b0, w_norm[30:26]};
    assign w_frac  = r_op ? w_norm[26 -: FRAC_W] : w_norm[25 -: FRAC_W];
    assign w_exp   = r_op ? {1'b0, w_p[4:1]} : w_p;

    // Interpolation: incpt - ((1 - slope/256) * frac), clamped at zero.
    assign w_slope = r_tbl[23:16];
    assign w_incpt = r_tbl[15:0];
    assign w_delta = 13'h1000 - 13'({w_slope, 4'h0});
    assign w_prod  = PROD_W'(w_delta) * PROD_W'(r_frac);
    assign w_corr  = 13'(w_prod >> FRAC_W);
    assign w_sub   = 17'(w_incpt) - 17'(w_corr);
    assign w_mant  = w_sub[16] ? 16'h0000 : w_sub[15:0];

    assign w_unused = ^{w_norm, w_prod};

    // Sequencer state and all registered outputs; flush overrides every transition.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state     <= S_IDLE;
            r_op        <= 1'b0;
            r_data      <= 32'd0;
            r_frac      <= '0;
            r_exp       <= 5'd0;
            r_tbl       <= 24'd0;
            r_tbl_index <= 6'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_mant  <= 16'd0;
            r_out_exp   <= 5'd0;
            r_out_dbz   <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.in_op;
                        r_data     <= bus.in_data;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_data == 32'd0) begin
                        r_out_dbz   <= 1'b1;
                        r_out_mant  <= 16'hffff;
                        r_out_exp   <= 5'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_tbl_index <= w_index;
                        r_frac      <= w_frac;
                        r_exp       <= w_exp;
                        r_state     <= S_LOOK;
                    end
                end
                S_LOOK: begin
                    r_tbl   <= tbl_data;
                    r_state <= S_INTP;
                end
                S_INTP: begin
                    r_out_mant  <= w_mant;
                    r_out_exp   <= r_exp;
                    r_out_dbz   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_mant  = r_out_mant;
    assign bus.out_exp   = r_out_exp;
    assign bus.out_dbz   = r_out_dbz;
    assign tbl_index     = r_tbl_index;
    assign busy          = r_busy;

endmodule

// File: tb/tb_div_pnt_seq.sv
// Self-checking bench for div_pnt_seq: directed plan items plus randomized operands
// against an arithmetic reference model and a randomly filled table.
module tb_div_pnt_seq;

    logic        clk;
    logic        reset_l;
    logic        flush;
    logic [5:0]  tbl_index;
    logic [23:0] tbl_data;
    logic        busy;

    logic [23:0] tbl [64];

    int checks;
    int errors;

    div_pnt_seq_if bus ();

    div_pnt_seq #(.FRAC_W(8)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .bus       (bus),
        .flush     (flush),
        .tbl_index (tbl_index),
        .tbl_data  (tbl_data),
        .busy      (busy)
    );

    assign tbl_data = tbl[tbl_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] mant;
        logic [4:0]  ex;
        logic        dbz;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference: value ~ 1/x or 1/sqrt(x) from normalised operand and table entry.
    function automatic res_t model(input logic op, input logic [31:0] d);
        res_t r;
        int p;
        longint n;
        int frac;
        int slope;
        int incpt;
        int delta;
        int v;
        r.idx = 6'd0;
        if (d == 32'd0) begin
            r.mant = 16'hffff;
            r.ex   = 5'd0;
            r.dbz  = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (d[i]) p = i;
        n = (longint'(d) << (31 - p)) & 64'hffff_ffff;
        if (!op) begin
            r.idx = 6'((n >> 26) & 31);
            frac  = int'((n >> 18) & 255);
            r.ex  = 5'(p);
        end else begin
            r.idx = 6'(((p % 2 == 0) ? 48 : 32) + ((n >> 27) & 15));
            frac  = int'((n >> 19) & 255);
            r.ex  = 5'(p / 2);
        end
        slope = int'(tbl[r.idx] >> 16);
        incpt = int'(tbl[r.idx] & 24'h00ffff);
        delta = 4096 - slope * 16;
        v = incpt - ((delta * frac) / 256);
        r.mant = (v < 0) ? 16'h0000 : 16'(v);
        r.dbz  = 1'b0;
        return r;
    endfunction

    // One full transaction: accept, latency, result, optional stall, handshake out.
    task automatic do_op(input logic op, input logic [31:0] d, input int hold);
        res_t e;
        int lat;
        e = model(op, d);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1 && d != 32'd0) chk("tbl_index", 32'(tbl_index), 32'(e.idx));
        end
        chk("latency", 32'(lat), (d == 32'd0) ? 32'd1 : 32'd3);
        chk("out_mant", 32'(bus.out_mant), 32'(e.mant));
        chk("out_exp", 32'(bus.out_exp), 32'(e.ex));
        chk("out_dbz", 32'(bus.out_dbz), 32'(e.dbz));
        chk("busy_done", 32'(busy), 32'd1);
        chk("in_ready_done", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_mant", 32'(bus.out_mant), 32'(e.mant));
            chk("hold_exp", 32'(bus.out_exp), 32'(e.ex));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        res_t e;
        logic [31:0] d;
        logic [15:0] held_mant;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) begin
            tbl[i][23:16] = 8'($urandom);
            tbl[i][15:0]  = (i % 4 == 0) ? 16'($urandom_range(0, 16'h0800)) : 16'($urandom);
        end
        tbl[6'h00] = 24'h08fff0;
        tbl[6'h10] = 24'h91554f;
        tbl[6'h20] = 24'h5469ff;
        tbl[6'h30] = 24'h08fff0;

        reset_l       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        #22;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_mant", 32'(bus.out_mant), 32'd0);
        chk("rst_out_exp", 32'(bus.out_exp), 32'd0);
        chk("rst_out_dbz", 32'(bus.out_dbz), 32'd0);
        chk("rst_tbl_index", 32'(tbl_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_l = 1'b1;
        @(posedge clk); #1;

        // Directed plan items, with the model cross-checked against hand values.
        e = model(1'b0, 32'd1);
        chk("model_rcp1", 32'(e.mant), 32'h0000fff0);
        do_op(1'b0, 32'd1, 0);
        e = model(1'b0, 32'd3);
        chk("model_rcp3", 32'(e.mant), 32'h0000554f);
        do_op(1'b0, 32'd3, 0);
        do_op(1'b1, 32'd4, 0);
        do_op(1'b1, 32'd2, 0);
        do_op(1'b0, 32'h0000_0041, 0);
        do_op(1'b0, 32'd0, 0);
        do_op(1'b1, 32'd0, 1);
        do_op(1'b0, 32'hffff_ffff, 0);
        do_op(1'b1, 32'hffff_ffff, 0);
        do_op(1'b0, 32'h8000_0000, 0);
        do_op(1'b0, 32'h1234_5678, 10);

        // Randomized operands over all leading-one positions.
        for (int t = 0; t < 60; t++) begin
            d = $urandom >> $urandom_range(0, 31);
            if (t % 13 == 0) d = 32'd0;
            do_op(1'($urandom), d, int'($urandom_range(0, 3)));
        end

        // Flush in LOOK: back to IDLE, no result pulse.
        held_mant = bus.out_mant;
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_data  = 32'h0000_00ab;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_mant_kept", 32'(bus.out_mant), 32'(held_mant));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("flush_no_pulse", 32'(bus.out_valid), 32'd0);
        end

        // Flush together with in_valid in IDLE: operand refused.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd5;
        flush        = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        chk("flush_idle_busy", 32'(busy), 32'd0);
        chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Flush while stalled in DONE.
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b1;
        bus.in_data  = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_done_in_ready", 32'(bus.in_ready), 32'd1);

        do_op(1'b0, 32'd7, 0);

        // Asynchronous reset in INTP.
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_data  = 32'h00f0_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset_l = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_mant", 32'(bus.out_mant), 32'd0);
        chk("arst_out_exp", 32'(bus.out_exp), 32'd0);
        chk("arst_out_dbz", 32'(bus.out_dbz), 32'd0);
        chk("arst_tbl_index", 32'(tbl_index), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #3;
        reset_l = 1'b1;
        @(posedge clk); #1;
        do_op(1'b1, 32'h0003_0000, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
